// File: rtl/inst_fetch_ctrl.sv
// IF-stage fetch sequencer: builds a 32-bit instruction byte by byte from icache or RAM.
// Define IFC_CACHE_EN to enable icache lookup and refill; undefined, every byte comes from RAM.
module inst_fetch_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_req,
  input  logic [31:0] if_pc,
  input  logic        if_flush,
  output logic        if_busy,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] cache_addr_read,
  input  logic        cache_hit,
  input  logic [7:0]  cache_data,
  output logic        cache_write,
  output logic [31:0] cache_addr_write,
  output logic [7:0]  cache_data_w,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [31:0] mem_a,
  input  logic [7:0]  mem_din
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [1:0]      k_q;
  logic [31:0]     pc_q;
  logic [31:0]     addr;
  logic [31:0]     inst_q;
  logic [3:0][7:0] b_q;
  logic            hit;

  assign addr = pc_q + {30'd0, k_q};

`ifdef IFC_CACHE_EN
  assign hit = cache_hit;
`else
  logic cache_unused;
  assign hit          = 1'b0;
  assign cache_unused = ^{cache_hit, cache_data};
`endif

  assign if_busy = (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else if (rdy) begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q    <= 2'd0;
      pc_q   <= 32'd0;
      b_q    <= '0;
      inst_q <= 32'd0;
    end else if (rdy) begin
      unique case (state_q)
        S_IDLE: begin
          if (if_req && !if_flush) begin
            pc_q <= if_pc;
            k_q  <= 2'd0;
          end
        end
        S_CHECK: begin
          if (hit) begin
            b_q[k_q] <= cache_data;
            k_q      <= k_q + 2'd1;
          end
        end
        S_WAIT: begin
          b_q[k_q] <= mem_din;
          k_q      <= k_q + 2'd1;
        end
        S_DONE: inst_q <= b_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (if_req) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (!hit) state_d = S_REQ;
        else if (k_q == 2'd3) state_d = S_DONE;
      end
      S_REQ: begin
        if (bus_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        state_d = (k_q == 2'd3) ? S_DONE : S_CHECK;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // an abort wins over everything, including a same-cycle request
    if (if_flush) state_d = S_IDLE;
  end

  always_comb begin
    bus_req          = 1'b0;
    mem_a            = 32'd0;
    cache_addr_read  = 32'd0;
    cache_write      = 1'b0;
    cache_addr_write = 32'd0;
    cache_data_w     = 8'd0;
    inst_valid       = 1'b0;
    inst             = inst_q;
    unique case (state_q)
      S_CHECK: begin
`ifdef IFC_CACHE_EN
        cache_addr_read = addr;
`endif
      end
      S_REQ: begin
        bus_req = 1'b1;
        mem_a   = addr;
      end
      S_WAIT: begin
        bus_req = 1'b1;
        mem_a   = addr;
`ifdef IFC_CACHE_EN
        cache_write      = rdy;
        cache_addr_write = addr;
        cache_data_w     = mem_din;
`endif
      end
      S_DONE: begin
        inst_valid = rdy;
        inst       = b_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Randomized scoreboard bench for inst_fetch_ctrl with icache, RAM and arbiter models.
module tb_inst_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        if_req;
  logic [31:0] if_pc;
  logic        if_flush;
  logic        if_busy;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] cache_addr_read;
  logic        cache_hit;
  logic [7:0]  cache_data;
  logic        cache_write;
  logic [31:0] cache_addr_write;
  logic [7:0]  cache_data_w;
  logic        bus_req;
  logic        bus_gnt;
  logic [31:0] mem_a;
  logic [7:0]  mem_din;

  inst_fetch_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req(if_req), .if_pc(if_pc), .if_flush(if_flush),
    .if_busy(if_busy), .inst_valid(inst_valid), .inst(inst),
    .cache_addr_read(cache_addr_read), .cache_hit(cache_hit),
    .cache_data(cache_data), .cache_write(cache_write),
    .cache_addr_write(cache_addr_write), .cache_data_w(cache_data_w),
    .bus_req(bus_req), .bus_gnt(bus_gnt),
    .mem_a(mem_a), .mem_din(mem_din)
  );

  typedef struct {
    logic [31:0] inst;
    int          cyc;
    int          nw;
    int          nm;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int gnt_delay = 0;
  int gcnt = 0;
  logic init_cache;

  logic        cv[16];
  logic [27:0] ct[16];
  logic [7:0]  cd[16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    case (a)
      32'h2000: return 8'hB7;
      32'h2001: return 8'h12;
      32'h2002: return 8'h34;
      32'h2003: return 8'h00;
      default:  return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
    endcase
  endfunction

  assign cache_hit  = cv[cache_addr_read[3:0]] &&
                      (ct[cache_addr_read[3:0]] == cache_addr_read[31:4]);
  assign cache_data = cd[cache_addr_read[3:0]];

  // small direct-mapped icache: 16 one-byte lines
  always @(posedge clk) begin
    if (init_cache) begin
      for (int i = 0; i < 16; i++) cv[i] <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cv[i] <= 1'b1;
        ct[i] <= 28'h100;
        cd[i] <= (i == 0) ? 8'h13 : 8'h00;
      end
      cv[8]  <= 1'b1; ct[8]  <= 28'h100; cd[8]  <= 8'hAA;
      cv[9]  <= 1'b1; ct[9]  <= 28'h100; cd[9]  <= 8'hBB;
      cv[11] <= 1'b1; ct[11] <= 28'h100; cd[11] <= 8'hDD;
    end else if (cache_write) begin
      cv[cache_addr_write[3:0]] <= 1'b1;
      ct[cache_addr_write[3:0]] <= cache_addr_write[31:4];
      cd[cache_addr_write[3:0]] <= cache_data_w;
    end
  end

  // arbiter grants gnt_delay cycles after the request rises; RAM has one cycle latency
  always @(posedge clk) begin
    #1;
    if (rst || !bus_req) begin
      gcnt    = 0;
      bus_gnt = 1'b0;
    end else begin
      bus_gnt = (gcnt >= gnt_delay);
      gcnt++;
    end
    mem_din = ram_byte(mem_a);
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  function automatic exp_t predict(input logic [31:0] pc, input int d);
    exp_t e;
    logic [31:0] a;
    logic h;
    int lat = 1;
    e.inst = 32'd0;
    e.nw = 0;
    e.nm = 0;
    for (int k = 0; k < 4; k++) begin
      a = pc + k;
`ifdef IFC_CACHE_EN
      h = cv[a[3:0]] && (ct[a[3:0]] == a[31:4]);
`else
      h = 1'b0;
`endif
      e.inst[8*k +: 8] = h ? cd[a[3:0]] : ram_byte(a);
      if (h) begin
        lat += 1;
      end else begin
        lat += 3 + d;
        e.nm++;
`ifdef IFC_CACHE_EN
        e.nw++;
`endif
      end
    end
    e.cyc = cyc + lat;
    return e;
  endfunction

  task automatic monitor();
    int wcount = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!if_busy) wcount = 0;
      if (cache_write) begin
        wcount++;
        check("fill_data", {24'd0, cache_data_w},
              {24'd0, ram_byte(cache_addr_write)});
      end
      if (inst_valid) begin
        if (sb.size() == 0) begin
          check("spurious_valid", {31'd0, inst_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("inst", inst, e.inst);
          check("strobe_cycle", cyc, e.cyc);
          check("fill_count", wcount, e.nw);
        end
      end else if (sb.size() > 0 && cyc > sb[0].cyc + 20) begin
        check("strobe_timeout", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (if_busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("idle_timeout", {31'd0, if_busy}, 32'd0);
  endtask

  task automatic wait_wait(output int ok);
    int run = 0;
    int n = 0;
    ok = 0;
    while (n < 200) begin
      run = (bus_req && bus_gnt) ? run + 1 : 0;
      if (run == 2) begin
        ok = 1;
        break;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic issue(input logic [31:0] pc);
    if_req = 1'b1;
    if_pc  = pc;
    @(negedge clk);
    if_req = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] pc, input int d, input bit stall);
    exp_t e;
    int ok;
    wait_idle();
    gnt_delay = d;
    e = predict(pc, d);
    if (stall && e.nm > 0) e.cyc += 2;
    else stall = 1'b0;
    sb.push_back(e);
    issue(pc);
    if (stall) begin
      wait_wait(ok);
      check("stall_reached_wait", ok, 1);
      rdy = 1'b0;
      repeat (2) @(negedge clk);
      rdy = 1'b1;
    end
  endtask

  task automatic flush_test(input logic [31:0] pc);
    int rises = 0;
    int n = 0;
    logic prev = 1'b0;
    wait_idle();
    gnt_delay = 4;
    issue(pc);
    while (n < 200) begin
      if (bus_req && !prev) rises++;
      prev = bus_req;
      if (rises == 2) break;
      @(negedge clk);
      n++;
    end
    check("flush_reached_req", rises, 2);
    if_flush = 1'b1;
    @(negedge clk);
    if_flush = 1'b0;
    check("flush_bus_req", {31'd0, bus_req}, 32'd0);
    check("flush_busy", {31'd0, if_busy}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"},
          {28'd0, if_busy, inst_valid, bus_req, cache_write}, 32'd0);
    check({tag, "_addr"},
          inst | mem_a | cache_addr_read | cache_addr_write |
          {24'd0, cache_data_w}, 32'd0);
  endtask

  task automatic rst_test(input logic [31:0] pc);
    int ok;
    wait_idle();
    gnt_delay = 0;
    issue(pc);
    wait_wait(ok);
    check("rst_reached_wait", ok, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    rdy        = 1'b1;
    if_req     = 1'b0;
    if_pc      = 32'd0;
    if_flush   = 1'b0;
    init_cache = 1'b1;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst        = 1'b0;
    init_cache = 1'b0;
    @(negedge clk);

    fetch(32'h0000_1000, 0, 1'b0);
    fetch(32'h0000_2000, 0, 1'b0);
    fetch(32'h0000_2000, 0, 1'b0);
    fetch(32'h0000_1008, 3, 1'b0);
    flush_test(32'h0000_5000);
    fetch(32'h0000_3000, int'($urandom_range(0, 3)), 1'b0);
    fetch(32'hFFFF_FFFE, 0, 1'b0);
    fetch(32'h0000_6000, int'($urandom_range(0, 2)), 1'b1);
    rst_test(32'h0000_7000);

    wait_idle();
    if_req   = 1'b1;
    if_flush = 1'b1;
    if_pc    = 32'h0000_9000;
    @(negedge clk);
    if_req   = 1'b0;
    if_flush = 1'b0;
    check("flush_over_req", {31'd0, if_busy}, 32'd0);

    for (int i = 0; i < 40; i++) begin
      fetch(32'h0000_8000 + $urandom_range(0, 47),
            int'($urandom_range(0, 3)),
            ($urandom_range(0, 4) == 0));
    end

    wait_idle();
    repeat (4) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
